// File: rtl/keccak_seq.sv
// Keccak sponge sequencer: absorbs padded blocks and steps the permutation
// one round per cycle, holding the finished hash until it is acknowledged.
module keccak_seq #(
  parameter int ROUNDS = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_ready,
  input  logic       is_last,
  input  logic       buffer_full,
  input  logic       pad_out_ready,
  input  logic       hash_ack,
  output logic       f_ack,
  output logic       absorb,
  output logic       round_en,
  output logic [4:0] round_idx,
  output logic       state_clr,
  output logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ABSORB,
    ROUND,
    DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

  state_t state;
  logic   last_seen;
  logic   block_last;
  logic   word_last;

  // The padder sees the final word when it accepts it, not when it emits.
  assign word_last = in_ready & is_last & ~buffer_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_seen  <= 1'b0;
      block_last <= 1'b0;
      round_idx  <= 5'd0;
    end else begin
      last_seen <= last_seen | word_last;
      unique case (state)
        IDLE: begin
          if (pad_out_ready) begin
            state      <= ABSORB;
            block_last <= last_seen;
            last_seen  <= word_last;
          end
        end
        ABSORB: begin
          state     <= ROUND;
          round_idx <= 5'd0;
        end
        ROUND: begin
          if (round_idx == LAST_IDX) begin
            state     <= block_last ? DONE : IDLE;
            round_idx <= 5'd0;
          end else begin
            round_idx <= round_idx + 5'd1;
          end
        end
        DONE: begin
          if (hash_ack)
            state <= IDLE;
        end
      endcase
    end
  end

  assign f_ack     = (state == ABSORB);
  assign absorb    = (state == ABSORB);
  assign round_en  = (state == ROUND);
  assign out_ready = (state == DONE);
  assign busy      = (state == ABSORB) | (state == ROUND);
  assign state_clr = (state == DONE) & hash_ack & ~reset;

endmodule

// File: tb/tb_keccak_seq.sv
// Bench for keccak_seq: two instances (24 and 2 rounds) checked each cycle
// against a countdown model, plus directed scenarios with literal timings.
module tb_keccak_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic in_ready = 1'b0;
  logic is_last = 1'b0;
  logic buffer_full = 1'b0;
  logic pad_out_ready = 1'b0;
  logic hash_ack = 1'b0;

  logic       f_ack[2];
  logic       absorb[2];
  logic       round_en[2];
  logic       state_clr[2];
  logic       out_ready[2];
  logic       busy[2];
  logic [4:0] ridx[2];

  int n_checks = 0;
  int n_fail = 0;
  int fack_cnt0 = 0;

  // model: remaining busy cycles, done flag, pending/current last flags
  int bl[2];
  bit dn[2];
  bit seen[2];
  bit blast[2];

  keccak_seq #(.ROUNDS(24)) u0 (
    .clk(clk), .reset(reset), .in_ready(in_ready), .is_last(is_last),
    .buffer_full(buffer_full), .pad_out_ready(pad_out_ready),
    .hash_ack(hash_ack), .f_ack(f_ack[0]), .absorb(absorb[0]),
    .round_en(round_en[0]), .round_idx(ridx[0]),
    .state_clr(state_clr[0]), .out_ready(out_ready[0]), .busy(busy[0])
  );

  keccak_seq #(.ROUNDS(2)) u1 (
    .clk(clk), .reset(reset), .in_ready(in_ready), .is_last(is_last),
    .buffer_full(buffer_full), .pad_out_ready(pad_out_ready),
    .hash_ack(hash_ack), .f_ack(f_ack[1]), .absorb(absorb[1]),
    .round_en(round_en[1]), .round_idx(ridx[1]),
    .state_clr(state_clr[1]), .out_ready(out_ready[1]), .busy(busy[1])
  );

  function automatic int rn(int i);
    return (i == 0) ? 24 : 2;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_step(int i);
    bit acc;
    acc = in_ready && is_last && !buffer_full;
    if (reset) begin
      bl[i] = 0;
      dn[i] = 1'b0;
      seen[i] = 1'b0;
      blast[i] = 1'b0;
      return;
    end
    if (bl[i] == 0 && !dn[i] && pad_out_ready) begin
      blast[i] = seen[i];
      seen[i] = acc;
      bl[i] = rn(i) + 1;
    end else begin
      seen[i] = seen[i] | acc;
      if (bl[i] > 0) begin
        bl[i]--;
        if (bl[i] == 0 && blast[i])
          dn[i] = 1'b1;
      end else if (dn[i] && hash_ack) begin
        dn[i] = 1'b0;
      end
    end
  endfunction

  always begin
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      model_step(i);
    #1;
    if (f_ack[0]) fack_cnt0++;
    for (int i = 0; i < 2; i++) begin
      int r;
      bit er;
      r = rn(i);
      er = (bl[i] >= 1) && (bl[i] <= r);
      chk($sformatf("f_ack%0d", i), int'(f_ack[i]), int'(bl[i] == r + 1));
      chk($sformatf("absorb%0d", i), int'(absorb[i]), int'(bl[i] == r + 1));
      chk($sformatf("round_en%0d", i), int'(round_en[i]), int'(er));
      chk($sformatf("round_idx%0d", i), int'(ridx[i]), er ? r - bl[i] : 0);
      chk($sformatf("out_ready%0d", i), int'(out_ready[i]), int'(dn[i]));
      chk($sformatf("busy%0d", i), int'(busy[i]), int'(bl[i] > 0));
      chk($sformatf("state_clr%0d", i), int'(state_clr[i]),
          int'(dn[i] && hash_ack && !reset));
    end
  end

  task automatic wait_idx(int v);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(posedge clk);
      #1;
      ok = round_en[0] && (ridx[0] == 5'(v));
    end
    chk($sformatf("wait_idx_%0d", v), int'(ok), 1);
  endtask

  initial begin
    int t0, t1, nf, k, fa0;
    bit fa;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_out_ready", int'(out_ready[0]), 0);
    chk("rst_round_idx", int'(ridx[0]), 0);
    chk("rst_f_ack", int'(f_ack[0]), 0);
    reset = 1'b0;

    // empty message
    @(negedge clk);
    in_ready = 1'b1;
    is_last = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    is_last = 1'b0;
    pad_out_ready = 1'b1;
    @(posedge clk);
    #1;
    nf = int'(f_ack[0]);
    t0 = -1;
    t1 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      pad_out_ready = 1'b0;
      @(posedge clk);
      #1;
      if (out_ready[0] && t0 < 0) t0 = c;
      if (out_ready[1] && t1 < 0) t1 = c;
      if (f_ack[0]) nf++;
    end
    chk("latency_24", t0, 25);
    chk("latency_2", t1, 3);
    chk("empty_f_ack_pulses", nf, 1);
    chk("model_done0", int'(dn[0]), 1);

    // hold in DONE with the padder offering a block
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      pad_out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_out_ready", int'(out_ready[0]), 1);
      chk("hold_f_ack", int'(f_ack[0]), 0);
    end
    @(negedge clk);
    pad_out_ready = 1'b0;
    hash_ack = 1'b1;
    #1;
    chk("release_state_clr", int'(state_clr[0]), 1);
    @(negedge clk);
    hash_ack = 1'b0;
    chk("release_out_ready", int'(out_ready[0]), 0);
    chk("release_busy", int'(busy[0]), 0);

    // two-block message, second block offered during rounds
    fa0 = fack_cnt0;
    @(negedge clk);
    pad_out_ready = 1'b1;
    @(negedge clk);
    pad_out_ready = 1'b0;
    wait_idx(5);
    @(negedge clk);
    pad_out_ready = 1'b1;
    in_ready = 1'b1;
    is_last = 1'b1;
    k = 0;
    fa = 1'b0;
    while (k < 60 && !fa) begin
      @(posedge clk);
      #1;
      k++;
      fa = f_ack[0];
      @(negedge clk);
      in_ready = 1'b0;
      is_last = 1'b0;
    end
    pad_out_ready = 1'b0;
    chk("ready_in_rounds_delay", k, 20);
    k = 0;
    while (k < 60 && !out_ready[0]) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("two_block_done", int'(out_ready[0]), 1);
    chk("two_block_f_acks", fack_cnt0 - fa0, 2);
    @(negedge clk);
    hash_ack = 1'b1;
    @(negedge clk);
    hash_ack = 1'b0;

    // reset in the middle of a round
    @(negedge clk);
    pad_out_ready = 1'b1;
    @(negedge clk);
    pad_out_ready = 1'b0;
    wait_idx(3);
    @(negedge clk);
    in_ready = 1'b1;
    is_last = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    is_last = 1'b0;
    wait_idx(12);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_busy", int'(busy[0]), 0);
    chk("midreset_round_idx", int'(ridx[0]), 0);
    chk("midreset_out_ready", int'(out_ready[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    pad_out_ready = 1'b1;
    @(negedge clk);
    pad_out_ready = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("midreset_last_cleared", int'(out_ready[0]), 0);
    chk("midreset_idle", int'(busy[0]), 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      in_ready = $urandom_range(0, 1) == 1;
      is_last = ($urandom_range(0, 7) == 0);
      buffer_full = ($urandom_range(0, 3) == 0);
      pad_out_ready = ($urandom_range(0, 5) == 0);
      hash_ack = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    in_ready = 1'b0;
    is_last = 1'b0;
    buffer_full = 1'b0;
    pad_out_ready = 1'b0;
    hash_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
